// File: rtl/vga_fb_reader.sv
// Frame-buffer read pipeline behind the 640x480 VGA timing generator.
// Realigns sync/blank with BRAM pixel data; bank swaps happen only in vsync.
module vga_fb_reader #(
  parameter int FB_W        = 320,
  parameter int FB_H        = 240,
  parameter int SCALE_SHIFT = 1,
  parameter int ADDR_W      = 17,
  parameter int PIX_W       = 12,
  parameter int MEM_LAT     = 2
) (
  input  logic              vclock,
  input  logic              reset_n,
  input  logic [9:0]        hcount,
  input  logic [9:0]        vcount,
  input  logic              hsync,
  input  logic              vsync,
  input  logic              blank,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_bank,
  input  logic [PIX_W-1:0]  mem_rdata,
  input  logic              swap_req,
  output logic              swap_ack,
  output logic              frame_start,
  output logic [PIX_W-1:0]  rgb,
  output logic              hsync_out,
  output logic              vsync_out,
  output logic              blank_out
);

  localparam int MW = 10 + $clog2(FB_W + 1) + 1;

  typedef struct packed {
    logic hs;
    logic vs;
    logic blank;
    logic oob;
    logic fs;
  } side_t;

  localparam side_t SIDE_RST = '{
    hs: 1'b1, vs: 1'b1, blank: 1'b1, oob: 1'b0, fs: 1'b0
  };

  typedef enum logic {
    IDLE    = 1'b0,
    PENDING = 1'b1
  } swap_state_t;

  logic [9:0]    x;
  logic [9:0]    y;
  logic [MW-1:0] lin;
  logic          oob;
  side_t         side_a;
  side_t         pipe [MEM_LAT+1];
  side_t         tail;

  swap_state_t   state_q;
  swap_state_t   state_d;
  logic          bank_d;
  logic          ack_d;
  logic          vs_prev;
  logic          v_evt;

  assign x = hcount >> SCALE_SHIFT;
  assign y = vcount >> SCALE_SHIFT;

  // full-width product so large y never wraps before truncation
  assign lin = MW'(y) * MW'(FB_W) + MW'(x);

  assign oob = (MW'(x) >= MW'(FB_W)) ||
               (MW'(y) >= MW'(FB_H));

  assign side_a = '{
    hs:    hsync,
    vs:    vsync,
    blank: blank,
    oob:   oob,
    fs:    (hcount == 10'd0) && (vcount == 10'd0)
  };

  always_ff @(posedge vclock or negedge reset_n) begin
    if (!reset_n) begin
      mem_addr <= '0;
      for (int i = 0; i <= MEM_LAT; i++) begin
        pipe[i] <= SIDE_RST;
      end
    end else begin
      mem_addr <= oob ? '0 : ADDR_W'(lin);
      pipe[0]  <= side_a;
      for (int i = 1; i <= MEM_LAT; i++) begin
        pipe[i] <= pipe[i-1];
      end
    end
  end

  assign tail = pipe[MEM_LAT];

  always_ff @(posedge vclock or negedge reset_n) begin
    if (!reset_n) begin
      rgb         <= '0;
      hsync_out   <= 1'b1;
      vsync_out   <= 1'b1;
      blank_out   <= 1'b1;
      frame_start <= 1'b0;
    end else begin
      rgb         <= (tail.blank | tail.oob) ? '0 : mem_rdata;
      hsync_out   <= tail.hs;
      vsync_out   <= tail.vs;
      blank_out   <= tail.blank;
      frame_start <= tail.fs;
    end
  end

  // V: falling edge of the raw vsync input
  assign v_evt = vs_prev & ~vsync;

  always_comb begin
    state_d = state_q;
    bank_d  = mem_bank;
    ack_d   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (v_evt && swap_req) begin
          bank_d = ~mem_bank;
          ack_d  = 1'b1;
        end else if (swap_req) begin
          state_d = PENDING;
        end
      end
      PENDING: begin
        if (v_evt) begin
          bank_d  = ~mem_bank;
          ack_d   = 1'b1;
          state_d = IDLE;
        end
      end
    endcase
  end

  always_ff @(posedge vclock or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= IDLE;
      mem_bank <= 1'b0;
      swap_ack <= 1'b0;
      vs_prev  <= 1'b1;
    end else begin
      state_q  <= state_d;
      mem_bank <= bank_d;
      swap_ack <= ack_d;
      vs_prev  <= vsync;
    end
  end

endmodule

// File: tb/tb_vga_fb_reader.sv
// Scoreboard bench for vga_fb_reader: directed timing cases plus
// randomized pixels/swap requests against a behavioural model.
module tb_vga_fb_reader;

  logic        vclock = 1'b0;
  logic        reset_n = 1'b1;
  logic [9:0]  hcount = 10'd645;
  logic [9:0]  vcount = 10'd200;
  logic        hsync = 1'b1;
  logic        vsync = 1'b1;
  logic        blank = 1'b1;
  logic [16:0] mem_addr;
  logic        mem_bank;
  logic [11:0] mem_rdata;
  logic        swap_req = 1'b0;
  logic        swap_ack;
  logic        frame_start;
  logic [11:0] rgb;
  logic        hsync_out;
  logic        vsync_out;
  logic        blank_out;

  vga_fb_reader dut (
    .vclock      (vclock),
    .reset_n     (reset_n),
    .hcount      (hcount),
    .vcount      (vcount),
    .hsync       (hsync),
    .vsync       (vsync),
    .blank       (blank),
    .mem_addr    (mem_addr),
    .mem_bank    (mem_bank),
    .mem_rdata   (mem_rdata),
    .swap_req    (swap_req),
    .swap_ack    (swap_ack),
    .frame_start (frame_start),
    .rgb         (rgb),
    .hsync_out   (hsync_out),
    .vsync_out   (vsync_out),
    .blank_out   (blank_out)
  );

  always #5 vclock = ~vclock;

  int cyc = 0;
  always @(posedge vclock) cyc <= cyc + 1;

  // two-cycle BRAM; bank 1 holds the inverted pattern of bank 0
  logic [17:0] r1 = '0;
  logic [17:0] r2 = '0;
  logic        force_fff = 1'b0;
  always @(posedge vclock) begin
    r1 <= {mem_bank, mem_addr};
    r2 <= r1;
  end
  assign mem_rdata = force_fff ? 12'hFFF :
                     (r2[17] ? ~r2[11:0] : r2[11:0]);

  typedef struct {
    int          due;
    logic [11:0] rgb;
    logic [3:0]  sb;
  } pix_t;

  typedef struct {
    int          due;
    logic [16:0] addr;
    logic        bank;
    logic        ack;
  } adr_t;

  pix_t pq[$];
  adr_t aq[$];
  pix_t pe;
  adr_t ae;

  int n_chk = 0;
  int n_fail = 0;

  bit m_bank = 0;
  bit m_pend = 0;
  bit m_prev_vs = 1;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual %0h required %0h (cycle %0d)",
               nm, act, exp, cyc);
    end
  endtask

  always @(negedge vclock) begin
    if (reset_n) begin
      if (aq.size() > 0 && aq[0].due < cyc) begin
        ae = aq.pop_front();
        chk("addr_due", 32'(cyc), 32'(ae.due));
      end
      if (aq.size() > 0 && aq[0].due == cyc) begin
        ae = aq.pop_front();
        chk("mem_addr", 32'(mem_addr), 32'(ae.addr));
        chk("mem_bank", 32'(mem_bank), 32'(ae.bank));
        chk("swap_ack", 32'(swap_ack), 32'(ae.ack));
      end
      if (pq.size() > 0 && pq[0].due == cyc) begin
        pe = pq.pop_front();
        chk("rgb", 32'(rgb), 32'(pe.rgb));
        chk("hs_vs_blank_fs",
            32'({hsync_out, vsync_out, blank_out, frame_start}),
            32'(pe.sb));
      end
    end
  end

  function automatic bit hs_of(int h);
    return !(h >= 656 && h < 752);
  endfunction

  function automatic bit vs_of(int v);
    return !(v >= 491 && v < 493);
  endfunction

  task automatic drive(input int h, input int v, input bit req,
                       input bit no_blank = 0);
    int x, y;
    bit hs, vs, bl, oob, fs, ack, vev;
    logic [16:0] addr;
    logic [11:0] data;
    pix_t p;
    adr_t a;
    @(posedge vclock);
    #1;
    hs = hs_of(h);
    vs = vs_of(v);
    bl = no_blank ? 1'b0 : (h >= 640 || v >= 480);
    fs = (h == 0 && v == 0);
    hcount = 10'(h);
    vcount = 10'(v);
    hsync = hs;
    vsync = vs;
    blank = bl;
    swap_req = req;
    vev = m_prev_vs && !vs;
    ack = 0;
    if (vev && (req || m_pend)) begin
      m_bank = !m_bank;
      ack = 1;
      m_pend = 0;
    end else if (req) begin
      m_pend = 1;
    end
    m_prev_vs = vs;
    x = h / 2;
    y = v / 2;
    oob = (x >= 320) || (y >= 240);
    addr = oob ? 17'd0 : 17'((y * 320 + x) % 131072);
    data = m_bank ? ~addr[11:0] : addr[11:0];
    a.due = cyc + 1;
    a.addr = addr;
    a.bank = m_bank;
    a.ack = ack;
    aq.push_back(a);
    p.due = cyc + 4;
    p.rgb = (bl || oob) ? 12'd0 : data;
    p.sb = {hs, vs, bl, fs};
    pq.push_back(p);
  endtask

  task automatic check_reset_vals();
    chk("rst_rgb", 32'(rgb), 32'd0);
    chk("rst_sync", 32'({hsync_out, vsync_out, blank_out, frame_start}),
        32'(4'b1110));
    chk("rst_addr", 32'(mem_addr), 32'd0);
    chk("rst_bank", 32'(mem_bank), 32'd0);
    chk("rst_ack", 32'(swap_ack), 32'd0);
  endtask

  // release mid-cycle; refill cycles must show reset/blank values
  task automatic release_rst();
    pix_t p;
    #3;
    reset_n = 1'b1;
    m_bank = 0;
    m_pend = 0;
    m_prev_vs = 1;
    for (int k = 0; k < 4; k++) begin
      p.due = cyc + 1 + k;
      p.rgb = 12'd0;
      p.sb = 4'b1110;
      pq.push_back(p);
    end
  endtask

  task automatic do_reset_mid();
    @(posedge vclock);
    #1;
    hcount = 10'd645;
    vcount = 10'd200;
    hsync = 1'b1;
    vsync = 1'b1;
    blank = 1'b1;
    swap_req = 1'b0;
    #2;
    reset_n = 1'b0;
    pq.delete();
    aq.delete();
    #1;
    check_reset_vals();
    repeat (3) @(posedge vclock);
    release_rst();
  endtask

  task automatic run_lines(input int v0, input int v1, input int r0,
                           input int r1l);
    for (int v = v0; v <= v1; v++) begin
      drive(0, v, (v == r0) || (v == r1l));
      drive(100, v, 0);
      drive(639, v, 0);
      drive(700, v, 0);
    end
  endtask

  initial begin
    #1;
    reset_n = 1'b0;
    #1;
    check_reset_vals();
    repeat (3) @(posedge vclock);
    release_rst();

    drive(5, 3, 0);
    drive(639, 479, 0);
    drive(10, 2, 0);
    drive(0, 0, 0);

    for (int h = 640; h < 800; h++) begin
      drive(h, 50, 0);
      if (h == 648) force_fff = 1'b1;
    end
    force_fff = 1'b0;
    drive(0, 51, 0);

    run_lines(0, 524, 100, -1);
    run_lines(0, 524, -1, -1);
    run_lines(0, 524, 100, 200);
    run_lines(0, 490, -1, -1);
    drive(0, 491, 1);
    run_lines(491, 524, -1, -1);
    run_lines(0, 524, -1, -1);

    if (!m_bank) begin
      run_lines(0, 524, 10, -1);
    end
    run_lines(0, 200, -1, -1);
    do_reset_mid();
    run_lines(0, 3, -1, -1);

    for (int i = 0; i < 4000; i++) begin
      int h, v;
      h = int'($urandom_range(0, 799));
      if ($urandom_range(0, 4) == 0) v = int'($urandom_range(486, 496));
      else v = int'($urandom_range(0, 524));
      drive(h, v, $urandom_range(0, 7) == 0,
            $urandom_range(0, 9) == 0);
    end
    drive(0, 10, 0);

    repeat (8) @(posedge vclock);
    #1;
    chk("drain", 32'(pq.size() + aq.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/vga_fb_reader.md
# vga_fb_reader

Downstream consumer of the 640x480 VGA timing generator. Takes the raw hcount/vcount/hsync/vsync/blank stream, computes a read address into a double-buffered, pixel-doubled frame buffer held in block RAM, and realigns the sync and blank signals with the returned pixel data. It also owns the display-bank register and performs frame-buffer swaps only inside vertical sync, so the renderer never tears the displayed image.

## Interface
Parameters:
- FB_W, 320: frame-buffer width in pixels.
- FB_H, 240: frame-buffer height in lines.
- SCALE_SHIFT, 1: screen-to-buffer downscale; x = hcount>>SCALE_SHIFT, y = vcount>>SCALE_SHIFT.
- ADDR_W, 17: address width per bank; must satisfy 2^ADDR_W >= FB_W*FB_H.
- PIX_W, 12: pixel width, RGB 4:4:4.
- MEM_LAT, 2: fixed BRAM read latency in cycles, from mem_addr to mem_rdata; must be 1 or more.

Ports (one clock, `vclock`; reset `reset_n`, asynchronous, active-low):
- vclock  in  1  pixel clock.
- reset_n  in  1  asynchronous active-low reset.
- hcount  in  10  pixel number from the timing generator.
- vcount  in  10  line number from the timing generator.
- hsync  in  1  active-low horizontal sync from the timing generator.
- vsync  in  1  active-low vertical sync from the timing generator.
- blank  in  1  blanking from the timing generator; 1 = not visible.
- mem_addr  out  ADDR_W  pixel read address within the displayed bank.
- mem_bank  out  1  bank currently displayed; the BRAM read-port bank select.
- mem_rdata  in  PIX_W  pixel data, valid MEM_LAT cycles after mem_addr.
- swap_req  in  1  single-cycle request from the renderer to swap banks.
- swap_ack  out  1  single-cycle pulse on the cycle the swap takes effect.
- frame_start  out  1  single-cycle pulse, aligned with the delayed hcount==0, vcount==0 position.
- rgb  out  PIX_W  output pixel.
- hsync_out, vsync_out, blank_out  out  1 each  delayed sync and blank, aligned with rgb.

## Operation
- Stage A (1 cycle): register x = hcount>>SCALE_SHIFT and y = vcount>>SCALE_SHIFT.
  - mem_addr = y*FB_W + x, truncated to ADDR_W.
  - oob = (x >= FB_W) | (y >= FB_H); when oob, mem_addr is 0.
- Memory stage: MEM_LAT cycles, with no local storage of pixel data.
- Output stage (1 cycle): rgb = (blank_d | oob_d) ? 0 : mem_rdata.
- Delay lines: hsync, vsync, blank, oob and the frame-start condition are carried through the same 1+MEM_LAT+1 register stages.
- Swap state is two registers, mem_bank and pending. Event V = input vsync 1 on the previous cycle and 0 now, sampled on the clock edge.
  - IDLE (pending=0): swap_req -> PENDING.
  - PENDING (pending=1): on V, toggle mem_bank, pulse swap_ack, return to IDLE.
  - swap_req on the same cycle as V, from either state: swap immediately; pending ends 0.
  - swap_req while already PENDING: absorbed, giving a single swap per V.
  - V without pending: no change.
- mem_bank changes only on V, therefore never during visible lines.

## Timing
- Latency: inputs to rgb/hsync_out/vsync_out/blank_out = MEM_LAT+2 cycles (4 at default), constant with no bubbles.
- mem_addr lags inputs by 1 cycle.
- mem_bank and swap_ack update on the same edge as V is detected, 1 cycle after the input vsync falls.
- Reset values (asynchronous assert, synchronous-clean deassert):
  - rgb = 0, mem_addr = 0, mem_bank = 0, pending = 0, swap_ack = 0, frame_start = 0.
  - hsync_out = 1, vsync_out = 1, blank_out = 1; all delay-line stages likewise.
  - Previous-vsync register = 1, so reset during vsync does not create a false V.
- Reset mid-frame: outputs are blanked immediately. After release, the pipeline refills for MEM_LAT+2 cycles with blank_out held 1, then tracks the inputs. No swap occurs until the next real V.
- Width rule: y*FB_W is computed at full width (y 10 bits × FB_W) before truncation.

## Test plan
- Address mapping: hcount=5, vcount=3 -> mem_addr=322 one cycle later. hcount=639, vcount=479 -> mem_addr=76799.
- Latency and alignment: drive mem_rdata=addr[11:0] from a 2-cycle BRAM model. rgb at hcount=10, vcount=2 output equals 325 (12'h145) exactly 4 cycles after those inputs, with blank_out=0.
- Blanking: during hcount 640-799, rgb=0 and blank_out=1 four cycles later, regardless of mem_rdata=12'hFFF.
- Swap: swap_req pulse at vcount=100 -> no change in mem_bank until input vsync falls (vcount 491); then mem_bank 0->1 and a one-cycle swap_ack. Next frame without a request -> no toggle.
- Collisions: two swap_req pulses in one frame -> a single toggle. swap_req on the V cycle -> toggle plus ack that cycle, and pending=0 afterwards.
- Reset mid-frame at vcount=200 with mem_bank=1 -> all outputs hold reset values immediately. After release, mem_bank=0 and outputs realign after 4 cycles.
